cic_decimator: RTL and testbench
================================

// Module: cic_decimator
// PURPOSE
//  Runtime-configurable CIC (Hogenauer) decimation filter for a 1-bit PDM/sigma-delta stream.
//  - Integrators run at the clk rate; combs run at clk/R.
//  - Delivers a 32-bit sample per decimation period with a one-cycle ready strobe.
//  - Sits between the PDM front end and downstream sample processing.
// PARAMETERS
//  MAX_STAGES  7   number of integrator/comb pairs built; comb_num selects how many are active
//  W           32  internal register and output width; all arithmetic is modulo 2^W
// PORTS
//  clk       in   1   single clock; one din sample per rising edge
//  rst       in   1   asynchronous, active-high reset
//  din       in   1   PDM input; 1 -> +1, 0 -> 0 (unsigned sample)
//  comb_num  in   3   active stage count N; 0 is treated as 1
//  dec_num   in   16  decimation ratio R; 0 and 1 both mean R=1 (output every cycle)
//  out       out  32  filtered, decimated sample (unsigned, modulo 2^32)
//  out_rdy   out  1   one-cycle strobe; out is valid in that cycle and holds until the next strobe
// BEHAVIOUR
//  - Reset (async assert): all integrators, comb delays, decimation counter, out=0, out_rdy=0.
//  - Integrators, pipelined: I1<=I1+din; Ik<=Ik+I(k-1) for k=2..MAX_STAGES, every cycle.
//  - Integrator tap: the comb input is I_N, N = effective comb_num.
//  - Decimation counter cnt:
//    - Counts 0..R-1 each cycle after reset release.
//    - Wraps to 0 when cnt>=R-1, so a lowered dec_num cannot overshoot.
//  - Decimation strobe: on the cycle with cnt>=R-1, the comb chain evaluates combinationally:
//    - C0 = I_N.
//    - Ck = C(k-1) - Dk, then Dk <= C(k-1), for k=1..N.
//    - out <= C_N; out_rdy <= 1 the next cycle; otherwise out_rdy <= 0.
//    - Comb delays Dk (k>N) are not updated.
//  - out_rdy period is exactly R cycles. The first strobe occurs R cycles after reset release.
//  - Steady-state DC gain is R^N. din constantly 1 settles to out = R^N.
//    - Exact only while N*ceil(log2 R)+1 <= 32; beyond that, results wrap modulo 2^32 (not an error).
//  - Settling: a din step reaches the final value within N+1 strobes and stays constant.
//  - comb_num / dec_num changes:
//    - Take effect immediately.
//    - out is undefined for the next N+1 strobes, then correct.
//    - Change them under reset when clean output is required.
//  - Reset mid-operation clears everything at once. Operation restarts as after power-up.
// STRUCTURE
//  - Shared package cic_pkg: MAX_STAGES, W, the stage index type, the effective-N and
//    effective-R helper functions (0->1 clamping).
//  - One natural sub-module, cic_comb_stage: a combinational difference plus an enabled delay register.
//    Instantiate it MAX_STAGES times in a generate loop. Integrators are inline.
// TESTING
//  - Reset values: assert rst for 2 cycles -> out=0 and out_rdy=0 throughout.
//  - Zero input: R=3, N=4, din=0 -> out_rdy every 3rd cycle, out=0 always.
//  - Step response: R=3, N=4, din 0 -> 1 -> out rises monotonically and equals 81 from the 5th strobe after the step onward.
//  - Single stage: R=4, N=1, din=1 -> out=4 from the 2nd strobe. With din alternating 1/0 -> out=2.
//  - Degenerate R: dec_num=0 and dec_num=1, N=1 -> out_rdy high every cycle, out follows din delayed.
//    - comb_num=0 behaves exactly as comb_num=1.
//  - Mid-run reset: R=3, N=4, steady at 81; pulse rst -> out=0 and out_rdy=0 immediately.
//    - First strobe 3 cycles after release; 81 again within 5 strobes.

Source files
------------

// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cic_pkg
// Purpose  : Shared constants, types and helpers for the CIC decimator.
//            - MAX_STAGES / W  : default stage count and datapath width
//            - stage_idx_t     : type that holds an active stage count
//            - eff_n / eff_r   : map the raw stage-count and ratio inputs to
//                                their effective values (0 behaves as 1)
// Revision : 1.0  initial release
// ============================================================================
package cic_pkg;

    localparam int MAX_STAGES = 7;
    localparam int W          = 32;
    localparam int DEC_W      = 16;

    typedef logic [2:0] stage_idx_t;

    // Effective active-stage count; a zero request runs one stage.
    function automatic stage_idx_t eff_n(input logic [2:0] comb_num);
        return (comb_num == 3'd0) ? 3'd1 : comb_num;
    endfunction

    // Effective decimation ratio; zero and one both give one output per cycle.
    function automatic logic [DEC_W-1:0] eff_r(input logic [DEC_W-1:0] dec_num);
        return (dec_num == '0) ? DEC_W'(1) : dec_num;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_comb_stage.sv
`default_nettype none
// ============================================================================
// Module   : cic_comb_stage
// Purpose  : One comb section of the CIC decimator: o_y = i_x - D, and the
//            delay D captures i_x on each cycle where i_en is high.
// Ports    : clk   clock
//            rst   asynchronous active-high reset (clears the delay)
//            i_en  delay update enable (decimation strobe for active stages)
//            i_x   comb input
//            o_y   comb output (combinational difference)
// Revision : 1.0  initial release
// ============================================================================
module cic_comb_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_y
);

    logic [W-1:0] r_dly;

    assign o_y = i_x - r_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dly <= '0;
        end else if (i_en) begin
            r_dly <= i_x;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : cic_decimator
// Purpose  : Runtime-configurable CIC (Hogenauer) decimator for a 1-bit PDM
//            stream. Integrators run every clock, combs run once per
//            decimation period; one 32-bit sample per period with a strobe.
// Ports    : clk       clock, one din sample per rising edge
//            rst       asynchronous active-high reset
//            din       PDM input bit (1 -> +1, 0 -> 0)
//            comb_num  active stage count N (0 behaves as 1)
//            dec_num   decimation ratio R (0 and 1 both mean 1)
//            out       filtered sample, modulo 2^W, held between strobes
//            out_rdy   one-cycle strobe marking a new out value
// Revision : 1.0  initial release
// ============================================================================
module cic_decimator #(
    parameter int MAX_STAGES = cic_pkg::MAX_STAGES,
    parameter int W          = cic_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    input  logic [2:0]   comb_num,
    input  logic [15:0]  dec_num,
    output logic [W-1:0] out,
    output logic         out_rdy
);

    import cic_pkg::*;

    logic [W-1:0]          r_integ [MAX_STAGES];
    logic [W-1:0]          w_stage_out [MAX_STAGES];
    logic [MAX_STAGES-1:0] w_en;
    logic [15:0]           r_cnt;
    logic [15:0]           w_r;
    stage_idx_t            w_n;
    logic                  w_strobe;
    logic [W-1:0]          w_tap;
    logic [W-1:0]          w_comb_out;
    logic [W-1:0]          r_out;
    logic                  r_rdy;

    // Effective configuration. The extra clamp only matters when the design
    // is built with fewer stages than comb_num can address.
    always_comb begin
        w_n = eff_n(comb_num);
        if (int'(w_n) > MAX_STAGES) begin
            w_n = stage_idx_t'(MAX_STAGES);
        end
    end

    assign w_r = eff_r(dec_num);

    // ">=" rather than "==" so that lowering dec_num while the counter is
    // already past the new terminal count still wraps at once.
    assign w_strobe = (r_cnt >= (w_r - 16'd1));

    // Pipelined integrator chain: every stage adds the previous stage's
    // registered value, so stage k lags stage 1 by k-1 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_STAGES; k++) begin
                r_integ[k] <= '0;
            end
        end else begin
            r_integ[0] <= r_integ[0] + W'(din);
            for (int k = 1; k < MAX_STAGES; k++) begin
                r_integ[k] <= r_integ[k] + r_integ[k-1];
            end
        end
    end

    // Tap selection and per-stage delay enables; stages beyond N keep
    // their delay contents untouched.
    always_comb begin
        w_tap = r_integ[0];
        for (int k = 0; k < MAX_STAGES; k++) begin
            if (k == int'(w_n) - 1) begin
                w_tap = r_integ[k];
            end
            w_en[k] = w_strobe && (k < int'(w_n));
        end
    end

    // Comb chain. Each generate scope owns its own wires so the chain is a
    // plain feed-forward path rather than one self-referencing array.
    for (genvar k = 0; k < MAX_STAGES; k++) begin : g_comb
        logic [W-1:0] w_x;
        logic [W-1:0] w_y;

        if (k == 0) begin : g_first
            assign w_x = w_tap;
        end else begin : g_rest
            assign w_x = g_comb[k-1].w_y;
        end

        cic_comb_stage #(
            .W (W)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_en[k]),
            .i_x  (w_x),
            .o_y  (w_y)
        );

        assign w_stage_out[k] = w_y;
    end

    // Output of the last active comb stage.
    always_comb begin
        w_comb_out = w_stage_out[0];
        for (int k = 0; k < MAX_STAGES; k++) begin
            if (k == int'(w_n) - 1) begin
                w_comb_out = w_stage_out[k];
            end
        end
    end

    // Decimation counter and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_out <= '0;
            r_rdy <= 1'b0;
        end else if (w_strobe) begin
            r_cnt <= '0;
            r_out <= w_comb_out;
            r_rdy <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 16'd1;
            r_rdy <= 1'b0;
        end
    end

    assign out     = r_out;
    assign out_rdy = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_decimator
// Purpose  : Directed self-checking bench for cic_decimator with
//            hand-computed expected values.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cic_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic [2:0]  comb_num;
    logic [15:0] dec_num;
    logic [31:0] out;
    logic        out_rdy;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    cic_decimator dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .comb_num (comb_num),
        .dec_num  (dec_num),
        .out      (out),
        .out_rdy  (out_rdy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next negedge on which out_rdy is high (bounded).
    // With tog set, din is inverted at every negedge while waiting.
    task automatic wait_strobe(input bit tog, output logic [31:0] val);
        int n;
        n = 0;
        @(negedge clk);
        if (tog) din = ~din;
        while (out_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            if (tog) din = ~din;
            n++;
        end
        if (out_rdy !== 1'b1) check("strobe_timeout", {31'b0, out_rdy}, 32'd1);
        val = out;
    endtask

    // Hold reset for two cycles with the given configuration, release on a negedge.
    task automatic restart(input logic d, input logic [2:0] n, input logic [15:0] r);
        @(negedge clk);
        rst      = 1'b1;
        din      = d;
        comb_num = n;
        dec_num  = r;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] prev;
        logic        dprev;
        logic [15:0] pattern;

        // ---------------- reset values ----------------
        rst      = 1'b1;
        din      = 1'b1;
        comb_num = 3'd4;
        dec_num  = 16'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_out", out, 32'd0);
            check("reset_rdy", {31'b0, out_rdy}, 32'd0);
        end

        // ---------------- zero input, R=3 N=4 ----------------
        restart(1'b0, 3'd4, 16'd3);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("zero_rdy", {31'b0, out_rdy}, (i % 3 == 0) ? 32'd1 : 32'd0);
            check("zero_out", out, 32'd0);
        end

        // ---------------- step 0 -> 1, R=3 N=4 ----------------
        din  = 1'b1;
        prev = 32'd0;
        for (int j = 1; j <= 10; j++) begin
            wait_strobe(1'b0, v);
            if (j <= 5) check("step_mono", 32'(v >= prev), 32'd1);
            if (j >= 5) check("step_81", v, 32'd81);
            prev = v;
        end

        // ---------------- mid-run reset ----------------
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out", out, 32'd0);
        check("midrst_rdy", {31'b0, out_rdy}, 32'd0);
        @(negedge clk);
        check("midrst_hold", out, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("midrst_first", {31'b0, out_rdy}, (i == 3) ? 32'd1 : 32'd0);
        end
        for (int j = 2; j <= 5; j++) begin
            wait_strobe(1'b0, v);
        end
        check("midrst_81", v, 32'd81);

        // ---------------- single stage, R=4 ----------------
        restart(1'b1, 3'd1, 16'd4);
        for (int j = 1; j <= 4; j++) begin
            wait_strobe(1'b0, v);
            if (j >= 2) check("single_dc", v, 32'd4);
        end
        wait_strobe(1'b1, v);
        for (int j = 0; j < 3; j++) begin
            wait_strobe(1'b1, v);
            check("single_alt", v, 32'd2);
        end

        // comb_num=0 acts as one stage
        restart(1'b1, 3'd0, 16'd4);
        for (int j = 1; j <= 3; j++) begin
            wait_strobe(1'b0, v);
            if (j >= 2) check("n0_dc", v, 32'd4);
        end

        // ---------------- degenerate R (0 and 1), N=1 ----------------
        pattern = 16'b1011_0010_1110_0101;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) restart(1'b1, 3'd0, 16'd0);
            else        restart(1'b1, 3'd1, 16'd1);
            dprev = 1'b0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                check("degen_rdy", {31'b0, out_rdy}, 32'd1);
                check("degen_out", out, {31'b0, dprev});
                dprev = din;
                din   = pattern[i];
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", err_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
